// File: rtl/mem_arbiter.sv
// Purpose: shares one line-wide data memory port between the I-cache and the D-cache.
// Latency: grant registered one edge after a request is seen in IDLE; ack/read data pass through combinationally.
// Backpressure: a request waits (enable held) while the port is busy or in the one-cycle GAP after an ack.
//
// Ports: clk_i / rst_i (async active-low); i_* I-cache request/ack/read line;
// d_* D-cache request/ack/read line; mem_* registered memory request plus
// memory read line and one-cycle ack; owner_o debug view of the current owner.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_enable_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [LINE_W-1:0] i_data_i,
    output logic              i_ack_o,
    output logic [LINE_W-1:0] i_data_o,
    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic              d_ack_o,
    output logic [LINE_W-1:0] d_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        owner_o
);

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_ack_done;
    logic                r_mem_enable;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_data;
    logic [1:0]          r_owner;
    logic [STREAK_W-1:0] r_d_streak;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decision. D has priority unless it has already
    // taken MAX_D_STREAK grants in a row while I was waiting.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_ack_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_enable_i && (!i_enable_i || (r_d_streak < STREAK_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (i_enable_i) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack_i) begin
                    w_ack_done   = 1'b1;
                    w_next_state = GAP;
                end
            end
            // One dead cycle so the owner can drop or re-present its request.
            GAP:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory request registers: loaded only on a grant, so they stay frozen
    // for the whole transaction whatever the requesters do meanwhile.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_owner      <= 2'b00;
            r_d_streak   <= '0;
        end else if (w_grant_d) begin
            r_mem_enable <= 1'b1;
            r_mem_write  <= d_write_i;
            r_mem_addr   <= d_addr_i;
            r_mem_data   <= d_data_i;
            r_owner      <= 2'b10;
            // Count only D wins taken at I's expense; saturate at the limit.
            if (!i_enable_i) begin
                r_d_streak <= '0;
            end else if (r_d_streak != STREAK_MAX) begin
                r_d_streak <= r_d_streak + STREAK_W'(1);
            end
        end else if (w_grant_i) begin
            r_mem_enable <= 1'b1;
            r_mem_write  <= i_write_i;
            r_mem_addr   <= i_addr_i;
            r_mem_data   <= i_data_i;
            r_owner      <= 2'b01;
            r_d_streak   <= '0;
        end else if (w_ack_done) begin
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_owner      <= 2'b00;
        end
    end

    // Acks are qualified by state, so stray acks in IDLE/GAP (or after a
    // reset abandoned a transaction) never reach a cache.
    assign i_ack_o      = mem_ack_i & (r_state == BUSY_I);
    assign d_ack_o      = mem_ack_i & (r_state == BUSY_D);
    assign i_data_o     = mem_data_i;
    assign d_data_o     = mem_data_i;
    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign owner_o      = r_owner;

endmodule
